// File: rtl/multi_alarm_clock.sv
// Multi-alarm 24-hour clock with multiplexed 8-digit seven-segment display.
//
// Time is kept as hh:mm:ss and advanced once per TICK_DIV clk_src cycles while
// running (power & enable). While paused (power & ~enable) each button bit
// steps its own field by one on a rising edge, wrapping within the field.
// NUM_ALARMS channels each hold {hh, mm, on}. A ring starts on the tick that
// lands on ss=0 at an enabled channel's hh:mm and lasts ALARM_SECS ticks.
//
// Optional feature: define HOURLY_CHIME_EN to add a one-second chime on every
// running tick that lands on mm=0, ss=0 (ORed into alarm).
//
// Ports:
//   clk_src            clock
//   reset              synchronous active-high reset (overrides power)
//   power              0 = clock off (time cleared, display blank)
//   enable             1 = run, 0 = pause/adjust
//   add_time/sub_time  increment/decrement buttons {hour, min, sec}
//   mode_12h           12-hour display format
//   alarm_wr           alarm channel write strobe
//   alarm_idx          channel index
//   alarm_hh/alarm_mm  alarm time
//   alarm_on           channel enable
//   alarm              ring/chime output
//   anodes             digit select, active-low
//   cnodes             segments {dp,g,f,e,d,c,b,a}, active-low
module multi_alarm_clock #(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned ALARM_SECS = 30
) (
    input  logic       clk_src,
    input  logic       reset,
    input  logic       power,
    input  logic       enable,
    input  logic [2:0] add_time,
    input  logic [2:0] sub_time,
    input  logic       mode_12h,
    input  logic       alarm_wr,
    input  logic [2:0] alarm_idx,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    input  logic       alarm_on,
    output logic       alarm,
    output logic [7:0] anodes,
    output logic [7:0] cnodes
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned RW = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;

    logic [PW-1:0]         presc_q, presc_d;
    logic [4:0]            hh_q, hh_d;
    logic [5:0]            mm_q, mm_d;
    logic [5:0]            ss_q, ss_d;
    logic [2:0]            add_prev_q, sub_prev_q;
    logic                  en_prev_q;
    logic [RW-1:0]         ring_q, ring_d;
    logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
    logic [2:0]            scan_idx_q, scan_idx_d;
    logic [4:0]            alm_hh_q [NUM_ALARMS];
    logic [5:0]            alm_mm_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] alm_on_q;
    logic [7:0]            anodes_q, cnodes_q, anodes_d, cnodes_d;

    logic       run, adj, tick, any_edge, en_fall, match, dash;
    logic [2:0] add_edge, sub_edge, inc, dec;
    logic [4:0] hour_disp;
    logic [3:0] digit;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    assign run      = power & enable;
    assign adj      = power & ~enable;
    assign tick     = run && (presc_q == PW'(TICK_DIV - 1));
    assign add_edge = add_time & ~add_prev_q & {3{adj}};
    assign sub_edge = sub_time & ~sub_prev_q & {3{adj}};
    // Opposing edges on the same field cancel out.
    assign inc      = add_edge & ~sub_edge;
    assign dec      = sub_edge & ~add_edge;
    assign any_edge = |(add_edge | sub_edge);
    assign en_fall  = en_prev_q & ~enable;

    // Prescaler and time-of-day next state
    always_comb begin
        presc_d = presc_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        if (!power) begin
            presc_d = '0;
            hh_d    = '0;
            mm_d    = '0;
            ss_d    = '0;
        end else if (enable) begin
            if (tick) begin
                presc_d = '0;
                if (ss_q == 6'd59) begin
                    ss_d = '0;
                    if (mm_q == 6'd59) begin
                        mm_d = '0;
                        hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
                    end else begin
                        mm_d = mm_q + 6'd1;
                    end
                end else begin
                    ss_d = ss_q + 6'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            if (inc[0])      ss_d = (ss_q == 6'd59) ? 6'd0 : ss_q + 6'd1;
            else if (dec[0]) ss_d = (ss_q == 6'd0) ? 6'd59 : ss_q - 6'd1;
            if (inc[1])      mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
            else if (dec[1]) mm_d = (mm_q == 6'd0) ? 6'd59 : mm_q - 6'd1;
            if (inc[2])      hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
            else if (dec[2]) hh_d = (hh_q == 5'd0) ? 5'd23 : hh_q - 5'd1;
        end
    end

    // Out-of-range stored alarm times can never equal a legal hh_d/mm_d.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            if (alm_on_q[i] && alm_hh_q[i] == hh_d && alm_mm_q[i] == mm_d) match = 1'b1;
        end
    end

    // Ring counter holds remaining ring seconds; a fresh match restarts it.
    always_comb begin
        ring_d = ring_q;
        if (!power || any_edge || en_fall) begin
            ring_d = '0;
        end else if (tick) begin
            if (ss_d == 6'd0 && match) ring_d = RW'(ALARM_SECS);
            else if (ring_q != '0)     ring_d = ring_q - RW'(1);
        end
    end

`ifdef HOURLY_CHIME_EN
    logic chime_q, chime_d;

    // Chime spans from the top-of-hour tick to the next tick.
    always_comb begin
        chime_d = chime_q;
        if (!run)      chime_d = 1'b0;
        else if (tick) chime_d = (mm_d == 6'd0) && (ss_d == 6'd0);
    end

    always_ff @(posedge clk_src) begin
        if (reset) chime_q <= 1'b0;
        else       chime_q <= chime_d;
    end

    assign alarm = (ring_q != '0) | chime_q;
`else
    assign alarm = (ring_q != '0);
`endif

    // Digit scan
    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        scan_idx_d = scan_idx_q;
        if (!power) begin
            scan_cnt_d = '0;
            scan_idx_d = '0;
        end else if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 3'd1;
        end
    end

    // Display decode from next-state values so outputs line up with the state.
    always_comb begin
        hour_disp = hh_d;
        if (mode_12h) begin
            if (hh_d == 5'd0)      hour_disp = 5'd12;
            else if (hh_d > 5'd12) hour_disp = hh_d - 5'd12;
        end
        dash  = 1'b0;
        digit = '0;
        case (scan_idx_d)
            3'd0:    digit = 4'(ss_d % 6'd10);
            3'd1:    digit = 4'(ss_d / 6'd10);
            3'd2:    dash  = 1'b1;
            3'd3:    digit = 4'(mm_d % 6'd10);
            3'd4:    digit = 4'(mm_d / 6'd10);
            3'd5:    dash  = 1'b1;
            3'd6:    digit = 4'(hour_disp % 5'd10);
            default: digit = 4'(hour_disp / 5'd10);
        endcase
        cnodes_d = dash ? 8'hBF : seg7(digit);
        if (scan_idx_d == 3'd0 && mode_12h && hh_d >= 5'd12) cnodes_d[7] = 1'b0;
        anodes_d = ~(8'd1 << scan_idx_d);
    end

    always_ff @(posedge clk_src) begin
        if (reset) begin
            presc_q    <= '0;
            hh_q       <= '0;
            mm_q       <= '0;
            ss_q       <= '0;
            add_prev_q <= '0;
            sub_prev_q <= '0;
            en_prev_q  <= 1'b0;
            ring_q     <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            anodes_q   <= 8'hFE;
            cnodes_q   <= 8'hC0;
            alm_on_q   <= '0;
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                alm_hh_q[i] <= '0;
                alm_mm_q[i] <= '0;
            end
        end else begin
            presc_q    <= presc_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            add_prev_q <= add_time;
            sub_prev_q <= sub_time;
            en_prev_q  <= enable;
            ring_q     <= ring_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            anodes_q   <= power ? anodes_d : 8'hFF;
            cnodes_q   <= power ? cnodes_d : 8'hFF;
            // Indices at or above NUM_ALARMS match no channel and are dropped.
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                if (alarm_wr && alarm_idx == 3'(i)) begin
                    alm_hh_q[i] <= alarm_hh;
                    alm_mm_q[i] <= alarm_mm;
                    alm_on_q[i] <= alarm_on;
                end
            end
        end
    end

    assign anodes = anodes_q;
    assign cnodes = cnodes_q;

endmodule
